// File: rtl/stall_pkg.sv
// Shared types and instruction field positions for the decode-stage hazard/stall unit.
package stall_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned REG_W   = 5;

    localparam int unsigned RS_HI = 25;
    localparam int unsigned RS_LO = 21;
    localparam int unsigned RT_HI = 20;
    localparam int unsigned RT_LO = 16;
    localparam int unsigned RD_HI = 15;
    localparam int unsigned RD_LO = 11;

    localparam logic [INSTR_W-1:0] NOP = 32'h0;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] dest;
    } sb_entry_t;

    typedef enum logic {
        RUN,
        BR_WAIT
    } stall_state_t;

endpackage

// File: rtl/stall_controller_if.sv
// Decode-side bundle between the decode control block and the stall controller.
interface stall_controller_if #(
    parameter int unsigned CNT_W = 16
);
    logic [31:0]      ip_instruction;
    logic             ip_R_format;
    logic             ip_I_format;
    logic             ip_Lw;
    logic             ip_Sw;
    logic             ip_Beq;
    logic             ip_branch_taken;
    logic             op_stall;
    logic             op_bubble;
    logic             op_flush;
    logic [CNT_W-1:0] op_stall_count;

    modport master (
        output ip_instruction, ip_R_format, ip_I_format, ip_Lw, ip_Sw, ip_Beq, ip_branch_taken,
        input  op_stall, op_bubble, op_flush, op_stall_count
    );

    modport slave (
        input  ip_instruction, ip_R_format, ip_I_format, ip_Lw, ip_Sw, ip_Beq, ip_branch_taken,
        output op_stall, op_bubble, op_flush, op_stall_count
    );
endinterface

// File: rtl/stall_scoreboard.sv
// In-flight destination tracker (EX/MEM/WB) with a two-source RAW compare.
// STALL_WB_BYPASS_EN: the WB entry is left out of the compare (register file writes first half-cycle).
module stall_scoreboard
    import stall_pkg::*;
#(
    parameter int unsigned HAZARD_DEPTH = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push_valid,
    input  logic [REG_W-1:0] push_dest,
    input  logic [REG_W-1:0] src_a,
    input  logic             use_a,
    input  logic [REG_W-1:0] src_b,
    input  logic             use_b,
    output logic             hit_c
);

`ifdef STALL_WB_BYPASS_EN
    localparam int unsigned CMP_DEPTH = HAZARD_DEPTH - 1;
`else
    localparam int unsigned CMP_DEPTH = HAZARD_DEPTH;
`endif

    sb_entry_t entry [HAZARD_DEPTH];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < int'(HAZARD_DEPTH); k++) begin
                entry[k] <= '0;
            end
        end else begin
            entry[0] <= '{valid: push_valid, dest: push_dest};
            for (int k = 1; k < int'(HAZARD_DEPTH); k++) begin
                entry[k] <= entry[k-1];
            end
        end
    end

    // Register 0 is hardwired, so it never creates a dependency.
    always_comb begin
        hit_c = 1'b0;
        for (int k = 0; k < int'(CMP_DEPTH); k++) begin
            if (entry[k].valid && (entry[k].dest != '0) &&
                ((use_a && (entry[k].dest == src_a)) || (use_b && (entry[k].dest == src_b)))) begin
                hit_c = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stall_controller.sv
// Hazard/stall unit: data-hazard stalls, branch resolution wait and a saturating stall counter.
// STALL_WB_BYPASS_EN (in stall_scoreboard) drops the WB stage from the hazard compare.
module stall_controller
    import stall_pkg::*;
#(
    parameter int unsigned HAZARD_DEPTH = 3,
    parameter int unsigned BRANCH_DELAY = 3,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clock,
    input  logic             reset,
    stall_controller_if.slave bus
);

    localparam int unsigned BR_CNT_W = $clog2(BRANCH_DELAY + 1);

    logic [REG_W-1:0]    rs_c, rt_c, rd_c, dest_c;
    logic                is_nop_c, use_rs_c, use_rt_c, dest_valid_c, hazard_c;
    logic                stall_c, bubble_c, flush_c;
    logic                unused_instr_bits_c;
    stall_state_t        state, state_next;
    logic [BR_CNT_W-1:0] br_cnt, br_cnt_next;
    logic [CNT_W-1:0]    stall_cnt;

    // Source/destination decode; overlapping flags take the union of sources, R before Lw for dest.
    always_comb begin
        rs_c         = bus.ip_instruction[RS_HI:RS_LO];
        rt_c         = bus.ip_instruction[RT_HI:RT_LO];
        rd_c         = bus.ip_instruction[RD_HI:RD_LO];
        is_nop_c     = (bus.ip_instruction == NOP);
        use_rs_c     = !is_nop_c && (bus.ip_R_format || bus.ip_I_format || bus.ip_Lw ||
                                     bus.ip_Sw || bus.ip_Beq);
        use_rt_c     = !is_nop_c && (bus.ip_R_format || bus.ip_Sw || bus.ip_Beq);
        dest_valid_c = !is_nop_c && (bus.ip_R_format || bus.ip_Lw);
        dest_c       = bus.ip_R_format ? rd_c : rt_c;
    end

    assign unused_instr_bits_c = ^{bus.ip_instruction[31:26], bus.ip_instruction[10:0]};

    stall_scoreboard #(
        .HAZARD_DEPTH(HAZARD_DEPTH)
    ) u_scoreboard (
        .clock      (clock),
        .reset      (reset),
        .push_valid (dest_valid_c && !bubble_c),
        .push_dest  (dest_c),
        .src_a      (rs_c),
        .use_a      (use_rs_c),
        .src_b      (rt_c),
        .use_b      (use_rt_c),
        .hit_c      (hazard_c)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= RUN;
            br_cnt <= '0;
        end else begin
            state  <= state_next;
            br_cnt <= br_cnt_next;
        end
    end

    // A data stall on a Beq wins; the branch wait starts only once the Beq leaves decode.
    always_comb begin
        state_next  = state;
        br_cnt_next = br_cnt;
        stall_c     = 1'b0;
        bubble_c    = 1'b0;
        flush_c     = 1'b0;
        case (state)
            RUN: begin
                if (hazard_c) begin
                    stall_c  = 1'b1;
                    bubble_c = 1'b1;
                end else if (bus.ip_Beq) begin
                    state_next  = BR_WAIT;
                    br_cnt_next = BR_CNT_W'(BRANCH_DELAY);
                end
            end
            BR_WAIT: begin
                stall_c     = 1'b1;
                bubble_c    = 1'b1;
                br_cnt_next = br_cnt - BR_CNT_W'(1);
                if (br_cnt == BR_CNT_W'(1)) begin
                    flush_c    = bus.ip_branch_taken;
                    state_next = RUN;
                end
            end
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (stall_c && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    assign bus.op_stall       = stall_c;
    assign bus.op_bubble      = bubble_c;
    assign bus.op_flush       = flush_c;
    assign bus.op_stall_count = stall_cnt;

endmodule

// File: doc/stall_controller.md
Name: stall_controller

Overview:
- Hazard/stall unit in the pipelined MIPS core, directly downstream of the decode control block.
- Consumes the decode-stage instruction and the R/I/Lw/Sw/Beq format flags.
- Tracks in-flight destination registers and resolves branches.
- Drives fetch stall, IF/ID flush and ID/EX bubble so the pipeline never reads a stale register or executes a wrong-path instruction.

Parameters:
- HAZARD_DEPTH, 3, number of in-flight stages tracked after decode (EX, MEM, WB).
- BRANCH_DELAY, 3, cycles from a Beq leaving decode until ip_branch_taken is valid (Beq resolves in MEM).
- CNT_W, 16, width of the stall performance counter.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- ip_instruction  input  32  instruction currently in decode (IF/ID register).
- ip_R_format  input  1  decode flag: opcode 000000.
- ip_I_format  input  1  decode flag: opcode[5:3]==001.
- ip_Lw  input  1  decode flag: load.
- ip_Sw  input  1  decode flag: store.
- ip_Beq  input  1  decode flag: branch-equal.
- ip_branch_taken  input  1  from MEM: branch & zero, valid in the last BR_WAIT cycle.
- op_stall  output  1  freeze PC and IF/ID this cycle.
- op_bubble  output  1  zero all control signals entering ID/EX this cycle.
- op_flush  output  1  load NOP (32'h0) into IF/ID at the next edge.
- op_stall_count  output  CNT_W  saturating count of cycles with op_stall=1.

Behaviour:
- Decode: NOP = instruction all zero. Sources: rs=[25:21], rt=[20:16].
  - R_format, Sw, Beq use rs and rt.
  - Lw and I_format use rs only.
  - NOP uses none.
- Destination: R_format non-NOP writes rd=[15:11]; Lw writes rt; all other instructions write none.
- Scoreboard: HAZARD_DEPTH entries of {valid, dest[4:0]}, shifted every clock.
  - Entry0 <= decode dest (valid only if instruction advances, i.e., op_bubble=0).
  - Entry k <= entry k-1. The last entry is discarded.
- Data hazard (combinational): any valid entry whose dest equals a used source and dest != 0.
  - Register 0 never hazards.
- FSM states RUN, BR_WAIT. Reset -> RUN.
- RUN:
  - If data hazard: op_stall=1, op_bubble=1; remain RUN.
  - Else if ip_Beq: the Beq advances (op_stall=0); load counter=BRANCH_DELAY; go to BR_WAIT.
  - Else all outputs 0.
- BR_WAIT:
  - op_stall=1 and op_bubble=1 every cycle; counter decrements.
  - At counter==1, sample ip_branch_taken.
    - If 1: op_flush=1 that cycle (wrong-path IF/ID replaced by NOP).
    - Go to RUN next cycle.
- Data hazard on a Beq: data stall takes priority; the branch wait begins only once the Beq advances.
- A hazard on the instruction after a branch is evaluated normally in RUN after the wait.
- Latency: stall decision is combinational from the decode inputs; scoreboard and FSM update on the clock edge.
- op_stall_count: +1 per cycle with op_stall=1; saturates at all-ones, no wrap.
- Reset (asynchronous, any time, including mid-BR_WAIT):
  - State RUN, scoreboard all invalid, counter 0, op_stall_count 0.
  - op_stall/op_bubble/op_flush = 0 while reset is asserted.
- Unused ip_Sw/ip_I_format combinations with multiple flags set: union of sources, first-match dest priority R > Lw.

Optional Feature:
- STALL_WB_BYPASS_EN defined: the register file writes in the first half-cycle, so the last scoreboard entry (WB) is excluded from the hazard compare.
  - A dependent instruction stalls at most HAZARD_DEPTH-1 cycles.
- Undefined: all HAZARD_DEPTH entries are compared; maximum data stall is HAZARD_DEPTH cycles.

Decomposition:
- Package stall_pkg:
  - typedef sb_entry_t {logic valid; logic [4:0] dest;}
  - enum stall_state_t {RUN, BR_WAIT}
  - localparams for field bit ranges (RS_HI/LO, RT_HI/LO, RD_HI/LO)
  - NOP constant 32'h0
- One sub-module: stall_scoreboard. It holds the shift register, enable for entry0 validity, and a compare output for two source addresses.

Test Plan:
- add $3,$1,$2 then add $5,$3,$4 back-to-back -> op_stall=op_bubble=1 for 3 cycles (2 with STALL_WB_BYPASS_EN); op_stall_count=3.
- lw $8,0($0) then sw $8,4($0) -> 3 stall cycles on rt source; an intervening independent instruction reduces the stall to 2.
- add $0,$1,$2 then add $4,$0,$0, and all-zero NOP sequences -> never stall.
- beq $1,$2 with ip_branch_taken=1 at counter==1 -> 3 stall cycles, op_flush=1 exactly in the 3rd; =0 -> no flush.
- Reset asserted asynchronously mid-BR_WAIT (counter=2) -> outputs drop to 0 immediately; after release, state RUN and a following independent add does not stall.
- Force 2^CNT_W+5 stall cycles (CNT_W=4 override: 21 cycles) -> op_stall_count holds at 4'hF.
